nanorv32_tcm_arbiter: RTL and testbench



---
 rtl/nanorv32_tcm_arbiter_if.sv | 38 +++
 rtl/nanorv32_tcm_arbiter.sv | 167 ++++++++++++++++
 tb/tb_nanorv32_tcm_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_tcm_arbiter_if.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_arbiter_if
//
// One requester port of the nanorv32 code-TCM arbiter. There is one instance
// each for instruction fetch, the CPU data port and the loader/debug host.
//
//   req    master -> slave  request; held stable with addr/we/wdata/wstrb until gnt
//   addr   master -> slave  byte address, bits [1:0] ignored
//   we     master -> slave  write enable (the fetch port never writes)
//   wdata  master -> slave  write data
//   wstrb  master -> slave  byte strobes, only meaningful when we=1
//   gnt    slave  -> master request accepted this cycle (combinational)
//   rvalid slave  -> master read data valid, one cycle after a granted read
//   rdata  slave  -> master read data, zero whenever rvalid is low
// -----------------------------------------------------------------------------
interface nanorv32_tcm_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/nanorv32_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_arbiter
//
// Shares the single-port nanorv32 code TCM between instruction fetch, the CPU
// data port and the program loader/debug host. The loader always wins; while
// ld_lock is high the CPU ports are locked out. Fetch and data share the
// remaining slots round-robin. Grants are combinational; read data comes back
// one cycle after the grant and is steered to the port that issued the read.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   if_port    fetch requester (read-only; write fields ignored)
//   dp_port    CPU data requester
//   ld_port    loader/debug requester
//   ld_lock    loader holds exclusive ownership of the memory
//   mem_cs     memory access this cycle
//   mem_we     byte write enables, zero for reads
//   mem_addr   word address
//   mem_wdata  write data
//   mem_rdata  read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module nanorv32_tcm_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    nanorv32_tcm_arbiter_if.slave   if_port,
    nanorv32_tcm_arbiter_if.slave   dp_port,
    nanorv32_tcm_arbiter_if.slave   ld_port,
    input  logic                    ld_lock,
    output logic                    mem_cs,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    // Which port is owed read data in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DP,
        OWN_LD
    } owner_e;

    owner_e rd_owner, rd_owner_nxt;
    logic   rr_last, rr_last_nxt;   // 0: fetch served last, 1: data served last
    logic   if_gnt, dp_gnt, ld_gnt;
    logic   cpu_ok;

    // The fetch port is read-only and byte-offset bits never reach the word
    // address; collecting them here documents that they are ignored on purpose.
    logic unused_bits;
    assign unused_bits = ^{if_port.we, if_port.wdata, if_port.wstrb,
                           if_port.addr[1:0], dp_port.addr[1:0], ld_port.addr[1:0]};

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on
        // every path (defaults first), otherwise synthesis infers a latch.
        ld_gnt = 1'b0;
        if_gnt = 1'b0;
        dp_gnt = 1'b0;
        cpu_ok = 1'b0;
        if (!rst) begin
            ld_gnt = ld_port.req;
            cpu_ok = !ld_port.req && !ld_lock;
            // Under contention the port that was not served last wins.
            if_gnt = cpu_ok && if_port.req && (!dp_port.req ||  rr_last);
            dp_gnt = cpu_ok && dp_port.req && (!if_port.req || !rr_last);
        end
    end

    assign if_port.gnt = if_gnt;
    assign dp_port.gnt = dp_gnt;
    assign ld_port.gnt = ld_gnt;

    // ------------------------------------------------------------------
    // Memory-side mux: only the granted port drives the macro
    // ------------------------------------------------------------------
    always_comb begin
        mem_cs    = if_gnt || dp_gnt || ld_gnt;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = ld_port.addr[ADDR_WIDTH-1:2];
            mem_wdata = ld_port.wdata;
            mem_we    = ld_port.we ? ld_port.wstrb : '0;
        end else if (dp_gnt) begin
            mem_addr  = dp_port.addr[ADDR_WIDTH-1:2];
            mem_wdata = dp_port.wdata;
            mem_we    = dp_port.we ? dp_port.wstrb : '0;
        end else if (if_gnt) begin
            mem_addr  = if_port.addr[ADDR_WIDTH-1:2];
        end
    end

    // ------------------------------------------------------------------
    // Next state: round-robin pointer and pending-read owner
    // ------------------------------------------------------------------
    always_comb begin
        rr_last_nxt  = rr_last;
        rd_owner_nxt = OWN_NONE;
        // Loader grants deliberately leave the round-robin pointer alone.
        if (if_gnt) begin
            rr_last_nxt = 1'b0;
        end else if (dp_gnt) begin
            rr_last_nxt = 1'b1;
        end
        // A no-op write (we=1, wstrb=0) is still a write: no read data owed.
        if (ld_gnt && !ld_port.we) begin
            rd_owner_nxt = OWN_LD;
        end else if (dp_gnt && !dp_port.we) begin
            rd_owner_nxt = OWN_DP;
        end else if (if_gnt) begin
            rd_owner_nxt = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value, independent of statement order.
        if (rst) begin
            rr_last  <= 1'b1;        // fetch wins the first contention
            rd_owner <= OWN_NONE;
        end else begin
            rr_last  <= rr_last_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read return: steer mem_rdata to the owner only. Gating with rst drops a
    // read that was still pending when reset arrived.
    // ------------------------------------------------------------------
    always_comb begin
        if_port.rvalid = 1'b0;
        dp_port.rvalid = 1'b0;
        ld_port.rvalid = 1'b0;
        if_port.rdata  = '0;
        dp_port.rdata  = '0;
        ld_port.rdata  = '0;
        if (!rst) begin
            case (rd_owner)
                OWN_IF: begin
                    if_port.rvalid = 1'b1;
                    if_port.rdata  = mem_rdata;
                end
                OWN_DP: begin
                    dp_port.rvalid = 1'b1;
                    dp_port.rdata  = mem_rdata;
                end
                OWN_LD: begin
                    ld_port.rvalid = 1'b1;
                    ld_port.rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nanorv32_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_tcm_arbiter
//
// Self-checking bench for nanorv32_tcm_arbiter. A behavioural TCM macro sits on
// the memory port; a separate reference image of the memory is updated from
// the intended stimulus. Every expected grant is checked in the cycle it is
// driven, and every expected read is pushed to a scoreboard and popped in the
// cycle its rvalid is due.
// -----------------------------------------------------------------------------
module tb_nanorv32_tcm_arbiter;

    localparam int AW    = 16;
    localparam int WW    = AW - 2;
    localparam int DEPTH = 1 << WW;

    typedef enum logic [1:0] {P_NONE, P_IF, P_DP, P_LD} port_e;

    typedef struct {
        port_e       port;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_lock = 1'b0;
    logic          mem_cs;
    logic [3:0]    mem_we;
    logic [WW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic [31:0]   mem     [DEPTH];
    logic [31:0]   ref_mem [DEPTH];

    rd_exp_t       sb[$];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    nanorv32_tcm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) if_p ();
    nanorv32_tcm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dp_p ();
    nanorv32_tcm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) ld_p ();

    nanorv32_tcm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_port   (if_p),
        .dp_port   (dp_p),
        .ld_port   (ld_p),
        .ld_lock   (ld_lock),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port TCM: read data one cycle after a read access.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we == 4'b0000)
                mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b])
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Distinct content per word; word 0x40 holds 32'hCAFFE000.
    function automatic logic [31:0] pat(input int w);
        logic [13:0] x;
        x = w[13:0];
        return 32'hCAFFE000 ^ {(x ^ 14'h0040), 18'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_if(input logic req, input logic [AW-1:0] addr);
        if_p.req   = req;
        if_p.addr  = addr;
        if_p.we    = 1'b0;
        if_p.wdata = '0;
        if_p.wstrb = '0;
    endtask

    task automatic set_dp(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        dp_p.req   = req;
        dp_p.we    = we;
        dp_p.addr  = addr;
        dp_p.wdata = wdata;
        dp_p.wstrb = wstrb;
    endtask

    task automatic set_ld(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        ld_p.req   = req;
        ld_p.we    = we;
        ld_p.addr  = addr;
        ld_p.wdata = wdata;
        ld_p.wstrb = wstrb;
    endtask

    task automatic idle();
        set_if(1'b0, '0);
        set_dp(1'b0, 1'b0, '0, '0, '0);
        set_ld(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Checks this cycle's grants and memory-side signals against the expected
    // winner, then records the effect: a write updates the reference image,
    // a read is queued for the next cycle.
    task automatic expect_gnt(input string tag, input logic ig, input logic dg, input logic lg);
        logic [WW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   wd;
        logic          wr;
        logic          any;
        port_e         p;
        rd_exp_t       e;
        #1;
        check({tag, "/if_gnt"}, 32'(if_p.gnt), 32'(ig));
        check({tag, "/dp_gnt"}, 32'(dp_p.gnt), 32'(dg));
        check({tag, "/ld_gnt"}, 32'(ld_p.gnt), 32'(lg));
        check({tag, "/mem_cs"}, 32'(mem_cs), 32'(ig | dg | lg));
        a = '0; we = '0; wd = '0; wr = 1'b0; any = 1'b1; p = P_NONE;
        if (lg) begin
            a = ld_p.addr[AW-1:2]; wr = ld_p.we; wd = ld_p.wdata; p = P_LD;
            we = wr ? ld_p.wstrb : 4'b0000;
        end else if (dg) begin
            a = dp_p.addr[AW-1:2]; wr = dp_p.we; wd = dp_p.wdata; p = P_DP;
            we = wr ? dp_p.wstrb : 4'b0000;
        end else if (ig) begin
            a = if_p.addr[AW-1:2]; p = P_IF;
        end else begin
            any = 1'b0;
        end
        check({tag, "/mem_we"}, 32'(mem_we), 32'(we));
        if (any) begin
            check({tag, "/mem_addr"}, 32'(mem_addr), 32'(a));
            if (wr) begin
                check({tag, "/mem_wdata"}, mem_wdata, wd);
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.port = p;
                e.data = ref_mem[a];
                e.due  = cyc + 1;
                sb.push_back(e);
            end
        end
    endtask

    // Compares all read-return outputs with the scoreboard entry due now.
    // A read still pending when rst is high is expected to be dropped.
    task automatic check_rvalid();
        port_e       ep;
        logic [31:0] ed;
        rd_exp_t     e;
        ep = P_NONE;
        ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (!rst) begin
                ep = e.port;
                ed = e.data;
            end
        end
        check("if_rvalid", 32'(if_p.rvalid), 32'(ep == P_IF));
        check("dp_rvalid", 32'(dp_p.rvalid), 32'(ep == P_DP));
        check("ld_rvalid", 32'(ld_p.rvalid), 32'(ep == P_LD));
        check("if_rdata",  if_p.rdata, (ep == P_IF) ? ed : 32'h0);
        check("dp_rdata",  dp_p.rdata, (ep == P_DP) ? ed : 32'h0);
        check("ld_rdata",  ld_p.rdata, (ep == P_LD) ? ed : 32'h0);
    endtask

    task automatic step();
        check_rvalid();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset with every port requesting: nothing granted, nothing returned.
        set_if(1'b1, 16'h0100);
        set_dp(1'b1, 1'b0, 16'h0200, '0, '0);
        set_ld(1'b1, 1'b0, 16'h0300, '0, '0);
        expect_gnt("rst0", 1'b0, 1'b0, 1'b0);
        step();
        expect_gnt("rst1", 1'b0, 1'b0, 1'b0);
        step();

        // Lone fetch read: same-cycle grant, data one cycle later.
        rst = 1'b0;
        idle();
        set_if(1'b1, 16'h0100);
        expect_gnt("fetch", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        expect_gnt("fetch_ret", 1'b0, 1'b0, 1'b0);
        step();

        // Reset clears the round-robin pointer (fetch was served last), so
        // fetch must still win the first contention.
        rst = 1'b1;
        expect_gnt("rr_rst", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        set_if(1'b1, 16'h0104);
        set_dp(1'b1, 1'b0, 16'h0208, '0, '0);
        for (int k = 0; k < 6; k++) begin
            expect_gnt($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1, 1'b0);
            step();
        end
        idle();
        expect_gnt("rr_drain", 1'b0, 1'b0, 1'b0);
        step();

        // Loader partial write preempts a pending fetch of the same word;
        // the fetch then reads back the merged word.
        set_ld(1'b1, 1'b1, 16'h0010, 32'h12345678, 4'b0011);
        set_if(1'b1, 16'h0010);
        expect_gnt("ld_wr", 1'b0, 1'b0, 1'b1);
        step();
        set_ld(1'b0, 1'b0, '0, '0, '0);
        expect_gnt("ld_wr_if", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        expect_gnt("ld_wr_drain", 1'b0, 1'b0, 1'b0);
        step();

        // Data read just before the lock; its rvalid lands in the first lock
        // cycle. Lock blocks CPU ports, the loader still gets through, and
        // after release fetch wins (data was served last).
        set_dp(1'b1, 1'b0, 16'h0020, '0, '0);
        expect_gnt("pre_lock", 1'b0, 1'b1, 1'b0);
        step();
        ld_lock = 1'b1;
        set_if(1'b1, 16'h0024);
        set_dp(1'b1, 1'b0, 16'h0028, '0, '0);
        for (int k = 0; k < 10; k++) begin
            expect_gnt($sformatf("lock%0d", k), 1'b0, 1'b0, 1'b0);
            step();
        end
        set_ld(1'b1, 1'b0, 16'h0030, '0, '0);
        expect_gnt("lock_ld", 1'b0, 1'b0, 1'b1);
        step();
        set_ld(1'b0, 1'b0, '0, '0, '0);
        ld_lock = 1'b0;
        expect_gnt("unlock_if", 1'b1, 1'b0, 1'b0);
        step();
        expect_gnt("unlock_dp", 1'b0, 1'b1, 1'b0);
        step();
        idle();
        expect_gnt("unlock_drain", 1'b0, 1'b0, 1'b0);
        step();

        // Reset while a data read is pending: its rvalid must not appear.
        set_dp(1'b1, 1'b0, 16'h0040, '0, '0);
        expect_gnt("rst_pend_dp", 1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        expect_gnt("rst_pend", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        set_if(1'b1, 16'h0044);
        expect_gnt("rst_pend_first", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        expect_gnt("rst_pend_drain", 1'b0, 1'b0, 1'b0);
        step();

        // Back-to-back reads dp, ld, if: rvalids follow in the same order.
        set_dp(1'b1, 1'b0, 16'h0050, '0, '0);
        expect_gnt("b2b_dp", 1'b0, 1'b1, 1'b0);
        step();
        set_dp(1'b0, 1'b0, '0, '0, '0);
        set_ld(1'b1, 1'b0, 16'h0010, '0, '0);
        expect_gnt("b2b_ld", 1'b0, 1'b0, 1'b1);
        step();
        set_ld(1'b0, 1'b0, '0, '0, '0);
        set_if(1'b1, 16'h0058);
        expect_gnt("b2b_if", 1'b1, 1'b0, 1'b0);
        step();
        idle();
        expect_gnt("b2b_drain", 1'b0, 1'b0, 1'b0);
        step();

        // No-op data write (wstrb=0) is granted with mem_we=0; then a full
        // write and read-back of the same word.
        set_dp(1'b1, 1'b1, 16'h0060, 32'hDEADBEEF, 4'b0000);
        expect_gnt("noop_wr", 1'b0, 1'b1, 1'b0);
        step();
        set_dp(1'b1, 1'b1, 16'h0060, 32'hDEADBEEF, 4'b1111);
        expect_gnt("full_wr", 1'b0, 1'b1, 1'b0);
        step();
        set_dp(1'b1, 1'b0, 16'h0060, '0, '0);
        expect_gnt("rd_back", 1'b0, 1'b1, 1'b0);
        step();
        idle();
        expect_gnt("rd_back_drain", 1'b0, 1'b0, 1'b0);
        step();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
